instr_encoder: RTL
==================

Name: instr_encoder

Overview:
Pipelined RV32I/A instruction encoder. It is the inverse of the `id` decoder: it takes decoded fields (opcode, rd, rs1, rs2, funct3, imm, funct7) and assembles the 32-bit instruction word. It sits in front of the `id` block in loopback benches and feeds the instruction-memory preload path. It uses a two-stage valid/ready pipeline, validates opcodes and immediate ranges, and keeps handshake counters.

Parameters:
INSTRUCTON_WIDTH, 32, instruction word width; only 32 is supported.
CNT_WIDTH, 16, width of the out_count and illegal_count counters.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  the field set on the in_* inputs is valid.
in_ready  output  1  the encoder can accept a field set this cycle.
in_opcode  input  7  opcode.
in_rd  input  5  destination register.
in_rs1  input  5  source register 1.
in_rs2  input  5  source register 2.
in_funct3  input  3  funct3 field.
in_imm  input  32  immediate, fully sign-extended as `id` produces it (U-type value is imm[31:12]<<12).
in_funct7  input  7  funct7 field.
out_valid  output  1  out_instruction is valid.
out_ready  input  1  downstream accepts the word this cycle.
out_instruction  output  32  encoded instruction word.
out_illegal  output  1  the opcode is unknown or the immediate is not representable; qualified by out_valid.
out_count  output  CNT_WIDTH  number of completed output handshakes; wraps.
illegal_count  output  CNT_WIDTH  number of completed output handshakes with out_illegal=1; wraps.

Behaviour:
- Reset, while rst=1 in any cycle:
  - All pipeline valids clear. out_valid=0, out_instruction=0, out_illegal=0, out_count=0, illegal_count=0.
  - in_ready=1 from the first cycle after reset.
  - Any in-flight words are dropped, with no partial output.
- Handshakes:
  - Input transfer when in_valid&in_ready. Output transfer when out_valid&out_ready.
  - Once out_valid=1, out_valid, out_instruction and out_illegal stay stable until the output transfer.
- Pipeline:
  - Stage 1 (S1) registers the fields and a one-hot type class {R,I,S,B,U,J,BAD}.
  - Stage 2 (S2) registers the assembled word and the illegal flag, and drives the out_* outputs.
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = ~s1_valid | s2_adv. This is a combinational path from out_ready.
- Latency and throughput:
  - Input transfer in cycle N gives out_valid=1 in cycle N+2.
  - Full throughput is 1 word per cycle with out_ready held at 1.
  - Order is preserved. Capacity is 2 words. With out_ready=0, exactly 2 transfers are accepted, then in_ready=0.
- Opcode classes:
  - R: 0110011, 0101111.
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0010111, 0110111.
  - J: 1101111.
  - Any other opcode is BAD.
- Encoding, shown MSB to LSB with "|" as concatenation:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I: imm[11:0]|rs1|funct3|rd|op.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - Fields that the format does not use are ignored.
- Illegal conditions:
  - BAD opcode: out_instruction=32'h0 and out_illegal=1.
  - Immediate out of range for the format:
    - I/S: imm[31:11] is not all-equal.
    - B: imm[31:12] is not all-equal, or imm[0]=1.
    - J: imm[31:20] is not all-equal, or imm[0]=1.
    - U: imm[11:0]≠0.
  - For an out-of-range immediate, out_illegal=1 and the word is still encoded from the truncated bits.
  - R type never sets out_illegal.
- Counters:
  - out_count increments on each output transfer.
  - illegal_count increments on each output transfer with out_illegal=1.
  - Both wrap from all-ones to 0.
- Simultaneous input and output transfer in the same cycle with the pipeline full: both occur and the occupancy stays 2.

Test Plan:
1. Reset, then addi x1,x0,5 (op 0010011, rd 1, rs1 0, f3 0, imm 5) -> 2 cycles later out_instruction=32'h00500093, out_illegal=0, out_count=1.
2. Back-to-back with out_ready=1:
   - add x3,x1,x2 -> 32'h002081B3.
   - sw x2,8(x1) -> 32'h0020A423.
   - beq x1,x2,+8 -> 32'h00208463.
   - jal x1,+8 -> 32'h008000EF.
   - lui x5,0x12345000 -> 32'h123452B7.
   - Expected: one word per cycle, in order, out_count=5.
3. Illegal cases:
   - opcode 7'b1111111 -> word 32'h0, out_illegal=1.
   - addi x1,x0,imm=2048 -> word 32'h80000093, out_illegal=1.
   - beq with imm=3 -> out_illegal=1.
   - Expected: illegal_count=3.
4. Backpressure: out_ready=0 with 3 words offered -> 2 accepted, in_ready=0, out_valid and word held stable. Set out_ready=1 -> all 3 words out in order with no loss or duplication.
5. Reset mid-operation: 2 words in flight, assert rst for 1 cycle -> out_valid=0, counters=0, in_ready=1, and neither in-flight word appears on the output.
6. Wrap: preload to out_count=16'hFFFF via 65535 transfers, then 1 more -> out_count=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Purpose: assembles RV32I/A instruction words from decoded fields, flags bad opcodes and out-of-range immediates.
// Latency: 2 cycles from input transfer to out_valid; 1 word/cycle sustained with out_ready held high.
// Backpressure: 2-entry valid/ready pipeline; in_ready combinationally follows out_ready when both stages are full.
module instr_encoder #(
    parameter int INSTRUCTON_WIDTH = 32,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  in_opcode,
    input  logic [4:0]                  in_rd,
    input  logic [4:0]                  in_rs1,
    input  logic [4:0]                  in_rs2,
    input  logic [2:0]                  in_funct3,
    input  logic [31:0]                 in_imm,
    input  logic [6:0]                  in_funct7,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTON_WIDTH-1:0] out_instruction,
    output logic                        out_illegal,
    output logic [CNT_WIDTH-1:0]        out_count,
    output logic [CNT_WIDTH-1:0]        illegal_count
);

    // one-hot format class bit positions
    localparam int CLS_R   = 0;
    localparam int CLS_I   = 1;
    localparam int CLS_S   = 2;
    localparam int CLS_B   = 3;
    localparam int CLS_U   = 4;
    localparam int CLS_J   = 5;
    localparam int CLS_BAD = 6;

    function automatic logic [6:0] classify(input logic [6:0] op);
        logic [6:0] c;
        c = '0;
        case (op)
            7'b0110011, 7'b0101111:                         c[CLS_R]   = 1'b1;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: c[CLS_I]   = 1'b1;
            7'b0100011:                                     c[CLS_S]   = 1'b1;
            7'b1100011:                                     c[CLS_B]   = 1'b1;
            7'b0010111, 7'b0110111:                         c[CLS_U]   = 1'b1;
            7'b1101111:                                     c[CLS_J]   = 1'b1;
            default:                                        c[CLS_BAD] = 1'b1;
        endcase
        return c;
    endfunction

    logic                        s1_valid;
    logic [6:0]                  s1_cls;
    logic [6:0]                  s1_op;
    logic [4:0]                  s1_rd;
    logic [4:0]                  s1_rs1;
    logic [4:0]                  s1_rs2;
    logic [2:0]                  s1_f3;
    logic [31:0]                 s1_imm;
    logic [6:0]                  s1_f7;

    logic                        s2_valid;
    logic [INSTRUCTON_WIDTH-1:0] s2_word;
    logic                        s2_illegal;

    logic                        s2_adv;
    logic                        s1_adv;
    logic                        in_xfer;
    logic                        out_xfer;

    logic [INSTRUCTON_WIDTH-1:0] enc_word;
    logic                        enc_illegal;
    logic                        imm_i_ok;
    logic                        imm_b_ok;
    logic                        imm_j_ok;
    logic                        imm_u_ok;

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = s1_valid & s2_adv;
    assign in_ready = ~s1_valid | s2_adv;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = s2_valid & out_ready;

    assign out_valid       = s2_valid;
    assign out_instruction = s2_word;
    assign out_illegal     = s2_illegal;

    // an immediate fits when every bit above the format's sign bit matches it
    assign imm_i_ok = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
    assign imm_b_ok = ((&s1_imm[31:12]) | ~(|s1_imm[31:12])) & ~s1_imm[0];
    assign imm_j_ok = ((&s1_imm[31:20]) | ~(|s1_imm[31:20])) & ~s1_imm[0];
    assign imm_u_ok = ~(|s1_imm[11:0]);

    // assemble the word from S1 fields; out-of-range immediates still encode their truncated bits
    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        if (s1_cls[CLS_R]) begin
            enc_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
        end else if (s1_cls[CLS_I]) begin
            enc_word    = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
            enc_illegal = ~imm_i_ok;
        end else if (s1_cls[CLS_S]) begin
            enc_word    = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
            enc_illegal = ~imm_i_ok;
        end else if (s1_cls[CLS_B]) begin
            enc_word    = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                           s1_imm[4:1], s1_imm[11], s1_op};
            enc_illegal = ~imm_b_ok;
        end else if (s1_cls[CLS_U]) begin
            enc_word    = {s1_imm[31:12], s1_rd, s1_op};
            enc_illegal = ~imm_u_ok;
        end else if (s1_cls[CLS_J]) begin
            enc_word    = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
            enc_illegal = ~imm_j_ok;
        end else if (s1_cls[CLS_BAD]) begin
            enc_word    = '0;
            enc_illegal = 1'b1;
        end
    end

    // stage 1: capture the field set and its format class on an input transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cls   <= '0;
            s1_op    <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_f3    <= '0;
            s1_imm   <= '0;
            s1_f7    <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_cls   <= classify(in_opcode);
            s1_op    <= in_opcode;
            s1_rd    <= in_rd;
            s1_rs1   <= in_rs1;
            s1_rs2   <= in_rs2;
            s1_f3    <= in_funct3;
            s1_imm   <= in_imm;
            s1_f7    <= in_funct7;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // stage 2: register the assembled word; held stable while the output is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_word    <= '0;
            s2_illegal <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word    <= enc_word;
                s2_illegal <= enc_illegal;
            end
        end
    end

    // handshake counters, both wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count     <= '0;
            illegal_count <= '0;
        end else if (out_xfer) begin
            out_count <= out_count + 1'b1;
            if (s2_illegal) begin
                illegal_count <= illegal_count + 1'b1;
            end
        end
    end

endmodule
